layer_ctrl_mem_responder: RTL and testbench



---
 rtl/layer_ctrl_mem_responder_pkg.sv | 12 +
 rtl/layer_ctrl_mem_array.sv | 18 +
 rtl/layer_ctrl_mem_responder.sv | 99 +++++++++
 tb/tb_layer_ctrl_mem_responder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/layer_ctrl_mem_responder_pkg.sv
// layer_ctrl_mem_responder_pkg: isolation hold level, responder FSM states and counter width.
`ifndef IO_HOLD
`define IO_HOLD 1'b1
`endif
package layer_ctrl_mem_responder_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;
    localparam int LC_MEM_CNT_W = 4;
endpackage

// File: rtl/layer_ctrl_mem_array.sv
// layer_ctrl_mem_array: single-port word storage with synchronous write and registered read.
module layer_ctrl_mem_array #(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/layer_ctrl_mem_responder.sv
// layer_ctrl_mem_responder: LC memory responder, fixed-latency word access over a 4-phase REQ/ACK.
// Define LC_MEM_OOR_ERR_EN to add MEM_ERR_IN, flagging out-of-range accesses alongside ACK.
module layer_ctrl_mem_responder
    import layer_ctrl_mem_responder_pkg::*;
#(
    parameter int LC_MEM_DATA_WIDTH = 32,
    parameter int LC_MEM_ADDR_WIDTH = 32,
    parameter int LC_MEM_DEPTH      = 256,
    parameter int LC_MEM_LATENCY    = 2
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         LC_ISOLATION,
    input  logic                         MEM_REQ_OUT,
    input  logic                         MEM_WRITE,
    input  logic [LC_MEM_DATA_WIDTH-1:0] MEM_DOUT,
    input  logic [LC_MEM_ADDR_WIDTH-3:0] MEM_AOUT,
`ifdef LC_MEM_OOR_ERR_EN
    output logic                         MEM_ERR_IN,
`endif
    output logic                         MEM_ACK_IN,
    output logic [LC_MEM_DATA_WIDTH-1:0] MEM_DATA_IN
);
    localparam int AW = LC_MEM_ADDR_WIDTH - 2;
    localparam int IW = $clog2(LC_MEM_DEPTH);

    state_t                   r_state;
    logic [LC_MEM_CNT_W-1:0]  r_cnt;
    logic                     r_write;
    logic [AW-1:0]            r_addr;
    logic [LC_MEM_DATA_WIDTH-1:0] r_data;
    logic                     w_req_q, w_last, w_in_range, w_fire, w_we;
    logic [IW-1:0]            w_idx;
    logic [LC_MEM_DATA_WIDTH-1:0] w_rdata;

    assign w_req_q    = MEM_REQ_OUT && (LC_ISOLATION != `IO_HOLD);
    assign w_last     = r_cnt == LC_MEM_CNT_W'(LC_MEM_LATENCY - 1);
    assign w_in_range = r_addr < AW'(LC_MEM_DEPTH);
    assign w_fire     = (r_state == ST_WAIT) && w_req_q && w_last;
    assign w_we       = w_fire && r_write && w_in_range;
    // Present the live address while idle so the registered read is ready even at latency 1.
    assign w_idx      = (r_state == ST_IDLE) ? MEM_AOUT[IW-1:0] : r_addr[IW-1:0];

    layer_ctrl_mem_array #(
        .DW    (LC_MEM_DATA_WIDTH),
        .DEPTH (LC_MEM_DEPTH),
        .IW    (IW)
    ) u_array (
        .i_clk   (CLK),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (r_data),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            MEM_ACK_IN  <= 1'b0;
            MEM_DATA_IN <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_req_q) begin
                    r_write <= MEM_WRITE;
                    r_addr  <= MEM_AOUT;
                    r_data  <= MEM_DOUT;
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_req_q) r_state <= ST_IDLE;
                    else if (w_last) begin
                        if (!r_write) MEM_DATA_IN <= w_in_range ? w_rdata : '0;
                        MEM_ACK_IN <= 1'b1;
                        r_state    <= ST_ACK;
                    end
                end
                ST_ACK: if (!w_req_q) begin
                    MEM_ACK_IN <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef LC_MEM_OOR_ERR_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) MEM_ERR_IN <= 1'b0;
        else if (w_fire) MEM_ERR_IN <= !w_in_range;
        else if (r_state == ST_ACK && !w_req_q) MEM_ERR_IN <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_layer_ctrl_mem_responder.sv
// tb_layer_ctrl_mem_responder: directed checks of latency, data, abort, isolation, range and reset.
`ifndef IO_HOLD
`define IO_HOLD 1'b1
`endif
module tb_layer_ctrl_mem_responder;
    localparam int LAT = 2;
    localparam logic HOLD = `IO_HOLD;
    logic        CLK = 1'b0, RESET = 1'b1, LC_ISOLATION = ~HOLD;
    logic        MEM_REQ_OUT = 1'b0, MEM_WRITE = 1'b0;
    logic [31:0] MEM_DOUT = '0;
    logic [29:0] MEM_AOUT = '0;
    logic        MEM_ACK_IN;
    logic [31:0] MEM_DATA_IN;
    logic [31:0] rd;
    logic        err_seen = 1'b0;
    int          n_tests = 0, n_fail = 0, n;
`ifdef LC_MEM_OOR_ERR_EN
    logic        MEM_ERR_IN;
`endif

    layer_ctrl_mem_responder #(.LC_MEM_LATENCY(LAT)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .LC_ISOLATION (LC_ISOLATION),
        .MEM_REQ_OUT  (MEM_REQ_OUT),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_DOUT     (MEM_DOUT),
        .MEM_AOUT     (MEM_AOUT),
`ifdef LC_MEM_OOR_ERR_EN
        .MEM_ERR_IN   (MEM_ERR_IN),
`endif
        .MEM_ACK_IN   (MEM_ACK_IN),
        .MEM_DATA_IN  (MEM_DATA_IN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ack(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!MEM_ACK_IN && cnt < 20);
    endtask

    // Full handshake; REQ is sampled at the first edge, so ACK shows after LAT+1 edges.
    task automatic txn(input string tag, input logic w, input logic [29:0] a,
                       input logic [31:0] d, output logic [31:0] data);
        int c;
        MEM_WRITE = w; MEM_AOUT = a; MEM_DOUT = d; MEM_REQ_OUT = 1'b1;
        wait_ack(c);
        check({tag, "_lat"}, 32'(c), 32'(LAT + 1));
        data = MEM_DATA_IN;
`ifdef LC_MEM_OOR_ERR_EN
        err_seen = MEM_ERR_IN;
`endif
        MEM_REQ_OUT = 1'b0;
        tick();
        check({tag, "_ack_fall"}, 32'(MEM_ACK_IN), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        check("rst_ack", 32'(MEM_ACK_IN), 32'd0);
        check("rst_data", MEM_DATA_IN, 32'd0);
        RESET = 1'b0;
        tick();

        txn("wr05", 1'b1, 30'h05, 32'hDEADBEEF, rd);
        txn("rd05", 1'b0, 30'h05, 32'h0, rd);
        check("rd05_data", rd, 32'hDEADBEEF);
        check("rd05_hold", MEM_DATA_IN, 32'hDEADBEEF);

        txn("b2b_w1", 1'b1, 30'h10, 32'h1, rd);
        txn("b2b_r1", 1'b0, 30'h10, 32'h0, rd);
        check("b2b_r1_data", rd, 32'h1);
        txn("b2b_w2", 1'b1, 30'h10, 32'h2, rd);
        txn("b2b_r2", 1'b0, 30'h10, 32'h0, rd);
        check("b2b_r2_data", rd, 32'h2);

        txn("pre20", 1'b1, 30'h20, 32'h55, rd);
        MEM_WRITE = 1'b1; MEM_AOUT = 30'h20; MEM_DOUT = 32'hAA; MEM_REQ_OUT = 1'b1;
        tick();
        MEM_REQ_OUT = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n += int'(MEM_ACK_IN);
        end
        check("abort_no_ack", 32'(n), 32'd0);
        txn("rd20", 1'b0, 30'h20, 32'h0, rd);
        check("rd20_data", rd, 32'h55);

        LC_ISOLATION = HOLD;
        MEM_WRITE = 1'b1; MEM_AOUT = 30'h30; MEM_DOUT = 32'h1234; MEM_REQ_OUT = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n += int'(MEM_ACK_IN);
        end
        check("iso_no_ack", 32'(n), 32'd0);
        LC_ISOLATION = ~HOLD;
        txn("iso_wr30", 1'b1, 30'h30, 32'h1234, rd);
        txn("rd30", 1'b0, 30'h30, 32'h0, rd);
        check("rd30_data", rd, 32'h1234);

        txn("wr44", 1'b1, 30'd44, 32'h44, rd);
        txn("oor_wr", 1'b1, 30'd300, 32'hFFFF, rd);
`ifdef LC_MEM_OOR_ERR_EN
        check("oor_wr_err", 32'(err_seen), 32'd1);
`endif
        txn("oor_rd", 1'b0, 30'd300, 32'h0, rd);
        check("oor_rd_data", rd, 32'h0);
`ifdef LC_MEM_OOR_ERR_EN
        check("oor_rd_err", 32'(err_seen), 32'd1);
        check("oor_err_fall", 32'(MEM_ERR_IN), 32'd0);
`endif
        txn("rd44", 1'b0, 30'd44, 32'h0, rd);
        check("rd44_data", rd, 32'h44);

        MEM_WRITE = 1'b0; MEM_AOUT = 30'h05; MEM_REQ_OUT = 1'b1;
        wait_ack(n);
        check("rst_mid_pre_ack", 32'(MEM_ACK_IN), 32'd1);
        RESET = 1'b1;
        #1;
        check("rst_mid_ack", 32'(MEM_ACK_IN), 32'd0);
        check("rst_mid_data", MEM_DATA_IN, 32'd0);
        MEM_REQ_OUT = 1'b0;
        tick();
        RESET = 1'b0;
        tick();
        txn("rd05_post_rst", 1'b0, 30'h05, 32'h0, rd);
        check("rd05_post_rst_data", rd, 32'hDEADBEEF);

        MEM_WRITE = 1'b1; MEM_AOUT = 30'h40; MEM_DOUT = 32'h11; MEM_REQ_OUT = 1'b1;
        tick();
        MEM_DOUT = 32'h22; MEM_AOUT = 30'h41; MEM_WRITE = 1'b0;
        wait_ack(n);
        check("latch_lat", 32'(n), 32'(LAT));
        MEM_REQ_OUT = 1'b0;
        tick();
        txn("rd40", 1'b0, 30'h40, 32'h0, rd);
        check("rd40_data", rd, 32'h11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
